operand_scoreboard: RTL and testbench

- Decode-stage producer-side companion to operand forwarding.
- Tracks in-flight destination registers whose results are not yet forwardable (loads, multi-cycle mul/div).
- Raises a stall so the forwarding mux only ever selects values that exist.
- Sits between the decoder and the ID/EX pipeline register; also keeps a saturating stall-cycle performance counter.

---
 rtl/operand_scoreboard_if.sv | 30 +++
 rtl/operand_scoreboard.sv | 87 ++++++++
 tb/tb_operand_scoreboard.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/operand_scoreboard_if.sv
// Decode-side bundle between the decoder and the operand scoreboard:
// issue/source fields in, stall and performance status out.
interface operand_scoreboard_if #(
    parameter int ADDRESS_W = 5,
    parameter int LAT_W     = 3,
    parameter int PERF_W    = 16
);
    logic [ADDRESS_W-1:0] RS1;
    logic [ADDRESS_W-1:0] RS2;
    logic                 rs1_used;
    logic                 rs2_used;
    logic                 iss_valid;
    logic                 iss_wen;
    logic [ADDRESS_W-1:0] iss_rd;
    logic [LAT_W-1:0]     iss_lat;
    logic                 flush;
    logic                 stall;
    logic                 any_pending;
    logic [PERF_W-1:0]    stall_cycles;

    modport master (
        output RS1, RS2, rs1_used, rs2_used, iss_valid, iss_wen, iss_rd, iss_lat, flush,
        input  stall, any_pending, stall_cycles
    );

    modport slave (
        input  RS1, RS2, rs1_used, rs2_used, iss_valid, iss_wen, iss_rd, iss_lat, flush,
        output stall, any_pending, stall_cycles
    );
endinterface

// File: rtl/operand_scoreboard.sv
// Per-register countdown scoreboard that stalls decode until every source
// operand is forwardable, plus a saturating stall-cycle counter.
module operand_scoreboard #(
    parameter int ADDRESS_W = 5,
    parameter int NREG      = 32,
    parameter int LAT_W     = 3,
    parameter int PERF_W    = 16
) (
    input logic                 clk,
    input logic                 reset,
    operand_scoreboard_if.slave sb
);
    localparam logic [ADDRESS_W-1:0] ADDR_ZERO = {ADDRESS_W{1'b0}};
    localparam logic [LAT_W-1:0]     LAT_ZERO  = {LAT_W{1'b0}};
    localparam logic [LAT_W-1:0]     LAT_ONE   = {{(LAT_W-1){1'b0}}, 1'b1};
    localparam logic [PERF_W-1:0]    PERF_ZERO = {PERF_W{1'b0}};
    localparam logic [PERF_W-1:0]    PERF_ONE  = {{(PERF_W-1){1'b0}}, 1'b1};
    localparam logic [PERF_W-1:0]    PERF_MAX  = {PERF_W{1'b1}};

    logic [LAT_W-1:0]  cnt_q [NREG];
    logic [LAT_W-1:0]  cnt_d [NREG];
    logic [PERF_W-1:0] stall_cycles_q;
    logic [PERF_W-1:0] stall_cycles_d;
    logic              raw1_s;
    logic              raw2_s;
    logic              waw_s;
    logic              stall_s;
    logic              issue_s;
    logic              any_pending_s;

    // Hazard detection; a WAW only stalls if the older write would land after the new one.
    always_comb begin
        raw1_s  = sb.rs1_used && (sb.RS1 != ADDR_ZERO) && (cnt_q[sb.RS1] != LAT_ZERO);
        raw2_s  = sb.rs2_used && (sb.RS2 != ADDR_ZERO) && (cnt_q[sb.RS2] != LAT_ZERO);
        waw_s   = sb.iss_wen && (sb.iss_rd != ADDR_ZERO) && (cnt_q[sb.iss_rd] > sb.iss_lat);
        stall_s = sb.iss_valid && (raw1_s || raw2_s || waw_s);
        issue_s = sb.iss_valid && sb.iss_wen && (sb.iss_rd != ADDR_ZERO) && !stall_s && !sb.flush;
    end

    // Summary of all busy registers, from state only.
    always_comb begin
        any_pending_s = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            any_pending_s = any_pending_s | (cnt_q[r] != LAT_ZERO);
        end
    end

    // Next-state: flush beats issue, issue beats countdown, zero stays zero.
    always_comb begin
        cnt_d[0] = LAT_ZERO;
        for (int r = 1; r < NREG; r++) begin
            if (sb.flush) begin
                cnt_d[r] = LAT_ZERO;
            end else if (issue_s && (sb.iss_rd == ADDRESS_W'(r))) begin
                cnt_d[r] = sb.iss_lat;
            end else if (cnt_q[r] != LAT_ZERO) begin
                cnt_d[r] = cnt_q[r] - LAT_ONE;
            end else begin
                cnt_d[r] = cnt_q[r];
            end
        end
        if (stall_s && (stall_cycles_q != PERF_MAX)) begin
            stall_cycles_d = stall_cycles_q + PERF_ONE;
        end else begin
            stall_cycles_d = stall_cycles_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= LAT_ZERO;
            end
            stall_cycles_q <= PERF_ZERO;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign sb.stall        = stall_s;
    assign sb.any_pending  = any_pending_s;
    assign sb.stall_cycles = stall_cycles_q;
endmodule

// File: tb/tb_operand_scoreboard.sv
// Directed bench for operand_scoreboard: a ready-time model checked every
// cycle, plus hand-computed checkpoints along each scenario.
module tb_operand_scoreboard;
    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    operand_scoreboard_if #(.ADDRESS_W(5), .LAT_W(3), .PERF_W(16)) sb_if ();

    operand_scoreboard #(.ADDRESS_W(5), .NREG(32), .LAT_W(3), .PERF_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .sb    (sb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Model: each register is free from an absolute cycle number onward.
    int free_at [32];
    int cyc;
    int exp_perf;
    bit model_on;

    function automatic int remaining(input int r);
        if (r == 0) return 0;
        return (free_at[r] > cyc) ? (free_at[r] - cyc) : 0;
    endfunction

    initial begin : compare
        bit e_stall;
        bit e_any;
        cyc      = 0;
        exp_perf = 0;
        model_on = 1'b0;
        for (int r = 0; r < 32; r++) free_at[r] = 0;
        forever begin
            @(negedge clk);
            e_stall = sb_if.iss_valid &&
                      ((sb_if.rs1_used && remaining(int'(sb_if.RS1)) > 0) ||
                       (sb_if.rs2_used && remaining(int'(sb_if.RS2)) > 0) ||
                       (sb_if.iss_wen && remaining(int'(sb_if.iss_rd)) > int'(sb_if.iss_lat)));
            e_any = 1'b0;
            for (int r = 1; r < 32; r++) if (remaining(r) > 0) e_any = 1'b1;
            if (model_on) begin
                check("model_stall", {31'd0, sb_if.stall}, {31'd0, e_stall});
                check("model_any_pending", {31'd0, sb_if.any_pending}, {31'd0, e_any});
                check("model_stall_cycles", {16'd0, sb_if.stall_cycles}, exp_perf);
            end
            if (reset) begin
                for (int r = 0; r < 32; r++) free_at[r] = 0;
                exp_perf = 0;
                model_on = 1'b1;
            end else begin
                if (e_stall && exp_perf < 65535) exp_perf++;
                if (sb_if.flush) begin
                    for (int r = 0; r < 32; r++) free_at[r] = 0;
                end else if (sb_if.iss_valid && sb_if.iss_wen && sb_if.iss_rd != 5'd0 && !e_stall) begin
                    free_at[int'(sb_if.iss_rd)] = cyc + 1 + int'(sb_if.iss_lat);
                end
            end
            cyc++;
        end
    end

    task automatic drv(input logic v, input logic [4:0] r1, input logic u1,
                       input logic [4:0] r2, input logic u2, input logic w,
                       input logic [4:0] rd, input logic [2:0] lat, input logic fl);
        sb_if.iss_valid = v;
        sb_if.RS1       = r1;
        sb_if.rs1_used  = u1;
        sb_if.RS2       = r2;
        sb_if.rs2_used  = u2;
        sb_if.iss_wen   = w;
        sb_if.iss_rd    = rd;
        sb_if.iss_lat   = lat;
        sb_if.flush     = fl;
    endtask

    task automatic idle();
        drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0);
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin : stimulus
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        drv(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst_stall", {31'd0, sb_if.stall}, 32'd0);
            check("rst_any_pending", {31'd0, sb_if.any_pending}, 32'd0);
            check("rst_stall_cycles", {16'd0, sb_if.stall_cycles}, 32'd0);
        end
        nxt();
        reset = 1'b0;
        idle();
        @(negedge clk);
        nxt();

        // Load-use: one stall cycle
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd5, 3'd1, 1'b0);
        @(negedge clk); check("lu_prod_stall", {31'd0, sb_if.stall}, 32'd0); nxt();
        drv(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0);
        @(negedge clk); check("lu_use_c1", {31'd0, sb_if.stall}, 32'd1); nxt();
        @(negedge clk); check("lu_use_c2", {31'd0, sb_if.stall}, 32'd0); nxt();
        idle();
        @(negedge clk); check("lu_perf", {16'd0, sb_if.stall_cycles}, 32'd1); nxt();

        // Divide: four stall cycles on RS2
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 3'd4, 1'b0);
        @(negedge clk); nxt();
        drv(1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 5'd0, 3'd0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check("div_stall", {31'd0, sb_if.stall}, (i <= 4) ? 32'd1 : 32'd0);
            if (i == 4) check("div_pending_c4", {31'd0, sb_if.any_pending}, 32'd1);
            if (i == 5) check("div_pending_c5", {31'd0, sb_if.any_pending}, 32'd0);
            nxt();
        end
        idle();
        @(negedge clk); check("div_perf", {16'd0, sb_if.stall_cycles}, 32'd5); nxt();

        // WAW: older lat=5 write blocks a lat=1 write while its count exceeds 1
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 3'd5, 1'b0);
        @(negedge clk); nxt();
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 3'd1, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check("waw_stall", {31'd0, sb_if.stall}, (i <= 4) ? 32'd1 : 32'd0);
            nxt();
        end
        idle();
        @(negedge clk); check("waw_pending_after", {31'd0, sb_if.any_pending}, 32'd1); nxt();
        @(negedge clk); check("waw_pending_done", {31'd0, sb_if.any_pending}, 32'd0);
        check("waw_perf", {16'd0, sb_if.stall_cycles}, 32'd9); nxt();

        // Register 0 and zero latency never create pending state
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 3'd7, 1'b0);
        @(negedge clk); nxt();
        drv(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0);
        @(negedge clk); check("r0_stall", {31'd0, sb_if.stall}, 32'd0);
        check("r0_pending", {31'd0, sb_if.any_pending}, 32'd0); nxt();
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 3'd0, 1'b0);
        @(negedge clk); nxt();
        drv(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0);
        @(negedge clk); check("lat0_stall", {31'd0, sb_if.stall}, 32'd0);
        check("lat0_pending", {31'd0, sb_if.any_pending}, 32'd0); nxt();

        // Flush: counted stall in flush cycle, then tracking cleared and no issue
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4, 3'd6, 1'b0);
        @(negedge clk); nxt();
        idle();
        @(negedge clk); check("fl_pending_c1", {31'd0, sb_if.any_pending}, 32'd1); nxt();
        drv(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1, 5'd6, 3'd2, 1'b1);
        @(negedge clk); check("fl_stall_c2", {31'd0, sb_if.stall}, 32'd1); nxt();
        drv(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b1, 5'd6, 3'd3, 1'b1);
        @(negedge clk); check("fl_stall_c3", {31'd0, sb_if.stall}, 32'd0);
        check("fl_pending_c3", {31'd0, sb_if.any_pending}, 32'd0); nxt();
        idle();
        @(negedge clk); check("fl_no_issue", {31'd0, sb_if.any_pending}, 32'd0);
        check("fl_perf", {16'd0, sb_if.stall_cycles}, 32'd10); nxt();

        // Reset mid-countdown
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd8, 3'd7, 1'b0);
        @(negedge clk); nxt();
        reset = 1'b1;
        drv(1'b1, 5'd8, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 3'd0, 1'b0);
        @(negedge clk); check("rm_stall_in_reset", {31'd0, sb_if.stall}, 32'd1); nxt();
        reset = 1'b0;
        @(negedge clk); check("rm_stall_after", {31'd0, sb_if.stall}, 32'd0);
        check("rm_pending_after", {31'd0, sb_if.any_pending}, 32'd0);
        check("rm_perf_cleared", {16'd0, sb_if.stall_cycles}, 32'd0); nxt();

        // RS1==RS2==rd hazards: one stall per cycle
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd10, 3'd2, 1'b0);
        @(negedge clk); nxt();
        drv(1'b1, 5'd10, 1'b1, 5'd10, 1'b1, 1'b1, 5'd10, 3'd0, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            check("dual_stall", {31'd0, sb_if.stall}, (i <= 2) ? 32'd1 : 32'd0);
            nxt();
        end
        idle();
        @(negedge clk); check("dual_perf", {16'd0, sb_if.stall_cycles}, 32'd2); nxt();

        // Saturation: self-dependent lat=7 re-issue stalls 7 of every 8 cycles
        drv(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd1, 3'd7, 1'b0);
        @(negedge clk); nxt();
        drv(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd1, 3'd7, 1'b0);
        repeat (75000) nxt();
        idle();
        @(negedge clk); check("sat_perf", {16'd0, sb_if.stall_cycles}, 32'h0000FFFF); nxt();
        @(negedge clk); check("sat_hold", {16'd0, sb_if.stall_cycles}, 32'h0000FFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
